gen1_tx_os_scheduler: RTL
=========================

// Module: gen1_tx_os_scheduler
// PURPOSE
//  Gen1 TX symbol scheduler in front of gen1_scramble. Arbitrates TLP/DLLP beats, LTSSM ordered sets and
//  periodic SKP ordered sets into one continuous per-lane symbol stream. Pads empty cycles with logical idle.
//  The output feeds the scrambler's data_in_i/data_k_in_i/data_valid_i.
// PARAMETERS
//  SKP_INTERVAL  1180  symbol times between SKP OS (Gen1 window 1180..1538)
//  CNT_W         12    width of the symbol-time counter
// PORTS
//  clk_i          in   1   clock, single domain
//  rst_i          in   1   synchronous, active-high reset
//  pipe_width_i   in   6   8/16/32 bits per beat; any other value is treated as 8
//  skp_enable_i   in   1   enables SKP insertion; when 0, pending is held but no SKP is emitted
//  tlp_data_i     in   32  link-layer beat; byte0 = first symbol
//  tlp_k_i        in   4   K flags per byte
//  tlp_valid_i    in   1   link-layer beat valid
//  tlp_eop_i      in   1   last beat of packet
//  tlp_ready_o    out  1   beat accepted when valid && ready
//  os_data_i      in   32  LTSSM ordered-set beat (TS1/TS2/EIOS)
//  os_k_i         in   4   K flags per byte
//  os_valid_i     in   1   ordered-set beat valid
//  os_last_i      in   1   last beat of the ordered set
//  os_ready_o     out  1   ordered-set beat accepted when valid && ready
//  data_out_o     out  32  to scrambler; bytes at or above pipe_width are driven 0
//  data_k_out_o   out  4   K flags; bytes at or above pipe_width are 0
//  data_valid_o   out  1   to scrambler
//  skp_pending_o  out  1   SKP interval elapsed, not yet served
//  underrun_o     out  1   one-cycle pulse: source gap inside a packet or ordered set
// BEHAVIOUR
//  Reset: data_out_o=0, data_k_out_o=0, data_valid_o=0, ready outputs=0, underrun_o=0, count=0, pending=0,
//   state=ST_IDLE, skp_idx=0. data_valid_o=1 every cycle after reset deasserts.
//  Latency: 1 cycle. The accepted or generated beat is registered onto the outputs at the next edge.
//  Ready outputs are combinational from state and grant.
//  Timer: count += pipe_width>>3 every non-reset cycle, saturating at 2^CNT_W-1.
//   pending set when count >= SKP_INTERVAL.
//   On the cycle the COM beat is emitted: count <= pipe_width>>3 and pending <= 0.
//   Reset of the timer wins over the threshold in that same cycle.
//  FSM states: ST_IDLE, ST_TLP, ST_OS, ST_SKP.
//  ST_IDLE priority: (pending && skp_enable_i) > os_valid_i > tlp_valid_i > logical idle.
//   Logical idle = data 0, k 0.
//   SKP granted: emit skp_idx 0. Go to ST_SKP unless width 32 (single beat).
//   OS granted: os_ready_o=1. Go to ST_OS unless os_last_i.
//   TLP granted: tlp_ready_o=1. Go to ST_TLP unless tlp_eop_i.
//  ST_TLP: tlp_ready_o=1 and os_ready_o=0. A packet is never preempted by SKP.
//   valid && eop -> ST_IDLE.
//   !tlp_valid_i -> emit logical idle, pulse underrun_o, stay in ST_TLP.
//  ST_OS: same rules as ST_TLP with the os_* ports; os_last_i -> ST_IDLE.
//  ST_SKP: both ready outputs 0. The SKP OS is COM(BC) SKP(1C) SKP SKP with k=1 on every symbol.
//   Emitted as 4 beats at width 8, 2 beats at width 16, 1 beat at width 32, low byte first.
//   skp_idx advances per beat; after the last beat, skp_idx=0 -> ST_IDLE.
//  pipe_width_i is sampled only in ST_IDLE. A change during ST_SKP/ST_TLP/ST_OS takes effect at the next
//   ST_IDLE decision.
//  Reset mid-operation drops the in-flight packet, OS or SKP. Upstream must restart the packet.
// STRUCTURE
//  pcie_phy_pkg (shared package):
//   add gen1_tx_sched_e {ST_IDLE,ST_TLP,ST_OS,ST_SKP} and SKP_OS_LEN=4.
//   reuse the existing COM/SKP constants.
//  Sub-module skp_interval_timer: owns count and pending. Inputs: width increment, clear. Outputs: pending.
//  Top level: FSM + output mux using the D/Q struct register style.
// TESTING
//  1 Width 32, no sources, skp_enable=1 -> data 0/k 0/valid 1 each cycle; SKP beat on cycle 296 after reset.
//    SKP beat = data 32'h1C1C1CBC, k 4'hF. Count reloads to 4.
//  2 Width 8, pending -> 4 beats BC,1C,1C,1C with k=1. tlp_ready_o/os_ready_o=0 throughout.
//    Next ST_IDLE decision proceeds normally.
//  3 Width 16, 10-beat TLP in flight when pending rises -> all 10 beats out unbroken.
//    SKP beats BC1C then 1C1C start the cycle after the eop output beat. tlp_ready_o=0 during SKP.
//  4 ST_IDLE with os_valid and tlp_valid both 1 -> OS granted, TLP held (ready 0) until os_last accepted.
//  5 tlp_valid low for 1 cycle mid-packet -> one idle beat, underrun_o=1 for 1 cycle, packet resumes.
//  6 rst_i asserted at width 8 during SKP beat 2 -> next cycle valid 0, data 0, count 0.
//    Stream restarts in ST_IDLE.

Source files
------------

// File: rtl/gen1_tx_os_scheduler_pkg.sv
// Shared definitions for the Gen1 TX symbol scheduler.
//   - FSM state encoding gen1_tx_sched_e
//   - SKP ordered-set symbols and length
//   - register bundle used by the top-level D/Q struct register
//   - helpers for PIPE width decoding and SKP beat generation
package gen1_tx_os_scheduler_pkg;

  localparam int unsigned SKP_OS_LEN = 4;
  localparam logic [7:0]  SYM_COM    = 8'hBC;
  localparam logic [7:0]  SYM_SKP    = 8'h1C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TLP  = 2'd1,
    ST_OS   = 2'd2,
    ST_SKP  = 2'd3
  } gen1_tx_sched_e;

  // Everything the scheduler keeps between cycles, including the registered outputs.
  typedef struct packed {
    gen1_tx_sched_e state;
    logic [1:0]     skp_idx;
    logic [2:0]     nbytes;
    logic [31:0]    data;
    logic [3:0]     k;
    logic           valid;
    logic           underrun;
  } sched_regs_t;

  // Bytes per beat; unsupported widths behave like 8 bits.
  function automatic logic [2:0] width_bytes(input logic [5:0] pipe_width);
    logic [2:0] nb;
    case (pipe_width)
      6'd16:   nb = 3'd2;
      6'd32:   nb = 3'd4;
      default: nb = 3'd1;
    endcase
    return nb;
  endfunction

  // One bit per active byte lane.
  function automatic logic [3:0] lane_mask(input logic [2:0] nbytes);
    logic [3:0] m;
    case (nbytes)
      3'd2:    m = 4'h3;
      3'd4:    m = 4'hF;
      default: m = 4'h1;
    endcase
    return m;
  endfunction

  // Expand a lane mask to a 32-bit data mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Index of the final SKP beat for a given beat width.
  function automatic logic [1:0] skp_last_idx(input logic [2:0] nbytes);
    logic [1:0] idx;
    case (nbytes)
      3'd2:    idx = 2'd1;
      3'd4:    idx = 2'd0;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // SKP beat: COM only in the very first symbol, SKP elsewhere, unused lanes 0.
  function automatic logic [31:0] skp_beat_data(input logic [1:0] idx, input logic [2:0] nbytes);
    logic [31:0] d;
    d = 32'd0;
    for (int b = 0; b < int'(SKP_OS_LEN); b++) begin
      if (b < int'(nbytes)) begin
        d[b*8 +: 8] = ((idx == 2'd0) && (b == 0)) ? SYM_COM : SYM_SKP;
      end else begin
        d[b*8 +: 8] = 8'h00;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/gen1_tx_os_scheduler_if.sv
// Handshake/bus bundle of the Gen1 TX scheduler.
// Signal suffixes are from the scheduler's point of view:
//   tlp_*   link-layer beat stream (ready driven by scheduler)
//   os_*    LTSSM ordered-set beat stream (ready driven by scheduler)
//   data_*  symbol stream towards the scrambler
// master = sources/sink around the scheduler, slave = the scheduler.
interface gen1_tx_os_scheduler_if;
  logic [31:0] tlp_data_i;
  logic [3:0]  tlp_k_i;
  logic        tlp_valid_i;
  logic        tlp_eop_i;
  logic        tlp_ready_o;
  logic [31:0] os_data_i;
  logic [3:0]  os_k_i;
  logic        os_valid_i;
  logic        os_last_i;
  logic        os_ready_o;
  logic [31:0] data_out_o;
  logic [3:0]  data_k_out_o;
  logic        data_valid_o;

  modport master (
    output tlp_data_i, tlp_k_i, tlp_valid_i, tlp_eop_i,
    output os_data_i, os_k_i, os_valid_i, os_last_i,
    input  tlp_ready_o, os_ready_o,
    input  data_out_o, data_k_out_o, data_valid_o
  );

  modport slave (
    input  tlp_data_i, tlp_k_i, tlp_valid_i, tlp_eop_i,
    input  os_data_i, os_k_i, os_valid_i, os_last_i,
    output tlp_ready_o, os_ready_o,
    output data_out_o, data_k_out_o, data_valid_o
  );
endinterface

// File: rtl/gen1_tx_os_scheduler_skp_interval_timer.sv
// SKP interval timer: counts symbol times and flags when a SKP OS is due.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   inc_i         symbol times elapsed this cycle (bytes per beat)
//   clear_i       COM beat emitted this cycle: reload count, drop pending
//   pending_o     interval elapsed and not yet served (sticky)
module skp_interval_timer #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] inc_i,
  input  logic       clear_i,
  output logic       pending_o
);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SKP_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic [CNT_W:0]   sum_s;

  // Saturating count; the reload on clear also wins over the threshold.
  always_comb begin
    sum_s = {1'b0, count_q} + (CNT_W+1)'(inc_i);
    if (clear_i) begin
      count_d   = CNT_W'(inc_i);
      pending_d = 1'b0;
    end else begin
      if (sum_s > {1'b0, CNT_MAX}) begin
        count_d = CNT_MAX;
      end else begin
        count_d = sum_s[CNT_W-1:0];
      end
      // Compared on the next value so pending aligns with the count crossing.
      pending_d = pending_q | (count_d >= THRESH);
    end
  end

  // Count and pending registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= {CNT_W{1'b0}};
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
endmodule

// File: rtl/gen1_tx_os_scheduler.sv
// Gen1 TX symbol scheduler placed in front of the scrambler.
// Merges link-layer beats, LTSSM ordered sets and periodic SKP ordered sets into one
// continuous symbol stream; empty cycles carry logical idle (data 0, k 0).
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   pipe_width_i    8/16/32 bits per beat (others behave as 8), sampled in ST_IDLE only
//   skp_enable_i    allows SKP emission; pending is held while low
//   bus             tlp/os sources with ready, symbol stream out (1-cycle latency)
//   skp_pending_o   SKP interval elapsed, not yet served
//   underrun_o      one-cycle pulse aligned with the idle beat of a mid-packet source gap
module gen1_tx_os_scheduler
  import gen1_tx_os_scheduler_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [5:0]              pipe_width_i,
  input  logic                    skp_enable_i,
  gen1_tx_os_scheduler_if.slave   bus,
  output logic                    skp_pending_o,
  output logic                    underrun_o
);
  localparam sched_regs_t REGS_RST = '{
    state:    ST_IDLE,
    skp_idx:  2'd0,
    nbytes:   3'd1,
    data:     32'd0,
    k:        4'd0,
    valid:    1'b0,
    underrun: 1'b0
  };

  sched_regs_t regs_q, regs_d;
  logic        pending_s;
  logic        skp_go_s;
  logic        tlp_rdy_s;
  logic        os_rdy_s;
  logic [2:0]  nb_live_s;
  logic [2:0]  nb_eff_s;
  logic [31:0] dmask_s;
  logic [3:0]  kmask_s;

  skp_interval_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (nb_eff_s),
    .clear_i   (skp_go_s),
    .pending_o (pending_s)
  );

  // Width in force: live input while idle, frozen copy inside a packet/OS/SKP.
  always_comb begin
    nb_live_s = width_bytes(pipe_width_i);
    nb_eff_s  = (regs_q.state == ST_IDLE) ? nb_live_s : regs_q.nbytes;
    kmask_s   = lane_mask(nb_eff_s);
    dmask_s   = lane_bits(kmask_s);
  end

  // Arbitration, FSM next state and next output beat.
  always_comb begin
    regs_d          = regs_q;
    regs_d.valid    = 1'b1;
    regs_d.underrun = 1'b0;
    regs_d.data     = 32'd0;
    regs_d.k        = 4'd0;
    skp_go_s        = 1'b0;
    tlp_rdy_s       = 1'b0;
    os_rdy_s        = 1'b0;
    case (regs_q.state)
      ST_IDLE: begin
        regs_d.nbytes  = nb_live_s;
        regs_d.skp_idx = 2'd0;
        if (pending_s && skp_enable_i) begin
          skp_go_s    = 1'b1;
          regs_d.data = skp_beat_data(2'd0, nb_live_s);
          regs_d.k    = kmask_s;
          if (nb_live_s == 3'd4) begin
            regs_d.state = ST_IDLE;
          end else begin
            regs_d.state   = ST_SKP;
            regs_d.skp_idx = 2'd1;
          end
        end else if (bus.os_valid_i) begin
          os_rdy_s     = 1'b1;
          regs_d.data  = bus.os_data_i & dmask_s;
          regs_d.k     = bus.os_k_i & kmask_s;
          regs_d.state = bus.os_last_i ? ST_IDLE : ST_OS;
        end else if (bus.tlp_valid_i) begin
          tlp_rdy_s    = 1'b1;
          regs_d.data  = bus.tlp_data_i & dmask_s;
          regs_d.k     = bus.tlp_k_i & kmask_s;
          regs_d.state = bus.tlp_eop_i ? ST_IDLE : ST_TLP;
        end else begin
          regs_d.state = ST_IDLE;
        end
      end
      ST_TLP: begin
        // Packets run to completion; SKP waits for the next idle decision.
        tlp_rdy_s = 1'b1;
        if (bus.tlp_valid_i) begin
          regs_d.data  = bus.tlp_data_i & dmask_s;
          regs_d.k     = bus.tlp_k_i & kmask_s;
          regs_d.state = bus.tlp_eop_i ? ST_IDLE : ST_TLP;
        end else begin
          regs_d.underrun = 1'b1;
          regs_d.state    = ST_TLP;
        end
      end
      ST_OS: begin
        os_rdy_s = 1'b1;
        if (bus.os_valid_i) begin
          regs_d.data  = bus.os_data_i & dmask_s;
          regs_d.k     = bus.os_k_i & kmask_s;
          regs_d.state = bus.os_last_i ? ST_IDLE : ST_OS;
        end else begin
          regs_d.underrun = 1'b1;
          regs_d.state    = ST_OS;
        end
      end
      ST_SKP: begin
        regs_d.data = skp_beat_data(regs_q.skp_idx, regs_q.nbytes);
        regs_d.k    = kmask_s;
        if (regs_q.skp_idx == skp_last_idx(regs_q.nbytes)) begin
          regs_d.skp_idx = 2'd0;
          regs_d.state   = ST_IDLE;
        end else begin
          regs_d.skp_idx = regs_q.skp_idx + 2'd1;
          regs_d.state   = ST_SKP;
        end
      end
      default: begin
        regs_d.skp_idx = 2'd0;
        regs_d.state   = ST_IDLE;
      end
    endcase
  end

  // State and registered output beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= REGS_RST;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.tlp_ready_o  = tlp_rdy_s & ~rst_i;
  assign bus.os_ready_o   = os_rdy_s & ~rst_i;
  assign bus.data_out_o   = regs_q.data;
  assign bus.data_k_out_o = regs_q.k;
  assign bus.data_valid_o = regs_q.valid;
  assign underrun_o       = regs_q.underrun;
  assign skp_pending_o    = pending_s;
endmodule
